// File: rtl/box_permutation_loader.sv
// box_permutation_loader - builds an LFSR-driven Fisher-Yates permutation and streams it
// into the boxes, then streams prisoner numbers into the prisoners.
module box_permutation_loader #(
  parameter int N_BOXES = 100,
  parameter int IDX_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             load_boxes,
  output logic             load_prisoners,
  output logic [IDX_W-1:0] select,
  output logic [IDX_W-1:0] data
);
  localparam int CW = IDX_W + 1;
  localparam logic [CW-1:0] LAST = CW'(N_BOXES - 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, LOAD_BOX, LOAD_PRIS, FIN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [31:0]      lfsr, lfsr_n, lfsr_adv;
  logic             busy_n, done_n, lb_n, lp_n;
  logic [IDX_W-1:0] sel_n, data_n;
  logic             init_we, swap_we;
  logic [IDX_W-1:0] idx, jdx;
  logic [8:0]       ip1;
  logic [24:0]      prod;
  logic [IDX_W-1:0] perm [N_BOXES];

  assign idx      = cnt[IDX_W-1:0];
  assign ip1      = 9'(cnt) + 9'd1;
  // 16-bit LFSR fraction scaled by (i+1): upper bits give an index in 0..i
  assign prod     = {9'b0, lfsr[15:0]} * {16'b0, ip1};
  assign jdx      = prod[16 +: IDX_W];
  assign lfsr_adv = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lfsr_n  = lfsr;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    lb_n    = 1'b0;
    lp_n    = 1'b0;
    sel_n   = '0;
    data_n  = '0;
    init_we = 1'b0;
    swap_we = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = INIT;
          cnt_n   = '0;
          lfsr_n  = (seed == 32'h0) ? 32'h1 : seed;
        end
      end
      INIT: begin
        busy_n  = 1'b1;
        init_we = 1'b1;
        if (cnt == LAST) begin
          state_n = SHUFFLE;
          cnt_n   = LAST;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHUFFLE: begin
        busy_n  = 1'b1;
        swap_we = 1'b1;
        lfsr_n  = lfsr_adv;
        if (cnt == CW'(1)) begin
          state_n = LOAD_BOX;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      LOAD_BOX: begin
        busy_n = 1'b1;
        lb_n   = 1'b1;
        sel_n  = idx;
        data_n = perm[idx];
        if (cnt == LAST) begin
          state_n = LOAD_PRIS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LOAD_PRIS: begin
        busy_n = 1'b1;
        lp_n   = 1'b1;
        sel_n  = idx;
        data_n = idx;
        if (cnt == LAST) begin
          state_n = FIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      FIN: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      lfsr           <= 32'h1;
      busy           <= 1'b0;
      done           <= 1'b0;
      load_boxes     <= 1'b0;
      load_prisoners <= 1'b0;
      select         <= '0;
      data           <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      lfsr           <= lfsr_n;
      busy           <= busy_n;
      done           <= done_n;
      load_boxes     <= lb_n;
      load_prisoners <= lp_n;
      select         <= sel_n;
      data           <= data_n;
    end
  end

  // perm needs no reset: every run rewrites all entries in INIT before use
  always_ff @(posedge clk) begin
    if (init_we) begin
      perm[idx] <= idx;
    end else if (swap_we) begin
      perm[idx] <= perm[jdx];
      perm[jdx] <= perm[idx];
    end
  end
endmodule

// File: tb/tb_box_permutation_loader.sv
// tb/tb_box_permutation_loader.sv - scoreboard bench for box_permutation_loader (N=100 and N=2 instances)
module tb_box_permutation_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        busy_a, done_a, lb_a, lp_a;
  logic [7:0]  sel_a, data_a;
  logic        busy_b, done_b, lb_b, lp_b;
  logic [0:0]  sel_b, data_b;

  always #5 clk = ~clk;

  box_permutation_loader #(.N_BOXES(100), .IDX_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed), .busy(busy_a), .done(done_a),
    .load_boxes(lb_a), .load_prisoners(lp_a), .select(sel_a), .data(data_a));

  box_permutation_loader #(.N_BOXES(2), .IDX_W(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed), .busy(busy_b), .done(done_b),
    .load_boxes(lb_b), .load_prisoners(lp_b), .select(sel_b), .data(data_b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic     kind;
    int       sel;
    int       data;
  } item_t;

  item_t sbq[$];
  int    mp[256];
  int    cap[256];
  int    prev[256];

  always @(negedge clk) begin
    assert (!(lb_a && lp_a) && !(lb_b && lp_b));
  end

  task automatic gen_perm(input logic [31:0] s, input int n);
    logic [31:0] l;
    int j, t;
    l = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < n; k++) mp[k] = k;
    for (int i = n - 1; i >= 1; i--) begin
      j = int'((longint'(l & 32'hFFFF) * longint'(i + 1)) >> 16);
      t = mp[i]; mp[i] = mp[j]; mp[j] = t;
      l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
    end
  endtask

  task automatic sample(input int which, output bit lb, output bit lp, output bit dn,
                        output bit by, output int sel, output int dat);
    if (which == 1) begin
      lb = lb_b; lp = lp_b; dn = done_b; by = busy_b; sel = int'(sel_b); dat = int'(data_b);
    end else begin
      lb = lb_a; lp = lp_a; dn = done_a; by = busy_a; sel = int'(sel_a); dat = int'(data_a);
    end
  endtask

  task automatic run(input int which, input logic [31:0] s, input int restart_at, input int rst_at);
    int    n, nb, np, done_cyc, sel, dat;
    bit    lb, lp, dn, by;
    bit    seen[256];
    item_t it;
    n = (which == 1) ? 2 : 100;
    nb = 0; np = 0; done_cyc = -1;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    gen_perm(s, n);
    sbq.delete();
    for (int k = 0; k < n; k++) sbq.push_back('{1'b0, k, mp[k]});
    for (int k = 0; k < n; k++) sbq.push_back('{1'b1, k, k});
    @(negedge clk);
    seed = s;
    if (which == 1) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4 * n + 20; c++) begin
      start_a = 1'b0; start_b = 1'b0;
      sample(which, lb, lp, dn, by, sel, dat);
      if (c == 0) check("busy_c0", by, 0);
      if (c == 1) check("busy_c1", by, 1);
      if (c == 4 * n) check("busy_at_done", by, 0);
      if (c == 4 * n + 10) check("busy_after", by, 0);
      if (lb || lp) begin
        check("mutex", lb && lp, 0);
        if (sbq.size() == 0) begin
          check("extra_strobe", 1, 0);
        end else begin
          it = sbq.pop_front();
          check("strobe_kind", lp, it.kind);
          check("strobe_sel", sel, it.sel);
          check("strobe_data", dat, it.data);
        end
        if (lb) begin
          if (nb == 0) check("first_box_cyc", c, 2 * n);
          check("box_data_unique", seen[dat & 255], 0);
          seen[dat & 255] = 1'b1;
          cap[nb & 255] = dat;
          nb++;
        end
        if (lp) begin
          if (np == 0) check("first_pris_cyc", c, 3 * n);
          np++;
        end
      end else begin
        check("idle_sel", sel, 0);
        check("idle_data", dat, 0);
      end
      if (dn) begin
        if (done_cyc < 0) done_cyc = c;
        else check("extra_done", 1, 0);
      end
      if (c == restart_at) begin
        if (which == 1) start_b = 1'b1; else start_a = 1'b1;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        sample(which, lb, lp, dn, by, sel, dat);
        check("rst_async_zero", {28'h0, lb, lp, dn, by} | sel | dat, 0);
        repeat (3) @(negedge clk);
        sample(which, lb, lp, dn, by, sel, dat);
        check("rst_hold_zero", {28'h0, lb, lp, dn, by} | sel | dat, 0);
        rst = 1'b0;
        sbq.delete();
        return;
      end
      @(negedge clk);
    end
    check("done_cycle", done_cyc, 4 * n);
    check("box_count", nb, n);
    check("pris_count", np, n);
    check("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int diffs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("reset_idle_a", {busy_a, done_a, lb_a, lp_a, sel_a, data_a}, 0);
      check("reset_idle_b", {busy_b, done_b, lb_b, lp_b, sel_b, data_b}, 0);
    end

    run(0, 32'h0000_00A5, -1, -1);

    run(0, 32'h0, -1, -1);
    for (int k = 0; k < 100; k++) prev[k] = cap[k];
    run(0, 32'h1, -1, -1);
    diffs = 0;
    for (int k = 0; k < 100; k++) if (prev[k] != cap[k]) diffs++;
    check("seed0_eq_seed1", diffs, 0);
    for (int k = 0; k < 100; k++) prev[k] = cap[k];
    run(0, 32'h2, -1, -1);
    diffs = 0;
    for (int k = 0; k < 100; k++) if (prev[k] != cap[k]) diffs++;
    check("seed1_ne_seed2", diffs != 0, 1);

    run(0, 32'h0000_00A5, 150, -1);

    run(0, 32'h7, -1, 250);
    run(0, 32'h7, -1, -1);

    run(1, 32'h1, -1, -1);
    check("n2_box0", cap[0], mp[0]);
    check("n2_box1", cap[1], mp[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
